cordic_rotvec: RTL and testbench

- Parametrised, fully pipelined CORDIC engine; successor to the fixed 16-bit rotator used in the TX/RX mixers.
- Per-sample mode selects rotation (rotate the complex input by a phase) or vectoring (return magnitude and angle of the input).
- Adds valid tagging, async reset, and configurable width, phase resolution and iteration count.
- Sits between the NCO phase accumulator / sample path and the CIC/FIR stages, and feeds the envelope/ALC detectors in vectoring mode.

---
 rtl/cordic_pkg.sv | 45 ++++
 rtl/cordic_stage.sv | 73 +++++++
 rtl/cordic_rotvec.sv | 158 +++++++++++++++
 tb/tb_cordic_rotvec.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the pipelined CORDIC: mode encoding and the arctangent
// table used to build each micro-rotation stage.
package cordic_pkg;

  localparam int   MAX_STAGES = 24;
  localparam logic MODE_ROT   = 1'b0;
  localparam logic MODE_VEC   = 1'b1;

  // atan(2^-k) scaled so that pi = 2^31, reduced to phase_w bits with rounding
  function automatic logic [31:0] atan_const(input logic [4:0] k, input int phase_w);
    logic [31:0] t;
    logic [32:0] r;
    case (k)
      5'd0:    t = 32'h2000_0000;
      5'd1:    t = 32'h12E4_051E;
      5'd2:    t = 32'h09FB_385B;
      5'd3:    t = 32'h0511_11D4;
      5'd4:    t = 32'h028B_0D43;
      5'd5:    t = 32'h0145_D7E1;
      5'd6:    t = 32'h00A2_F61E;
      5'd7:    t = 32'h0051_7C55;
      5'd8:    t = 32'h0028_BE53;
      5'd9:    t = 32'h0014_5F2F;
      5'd10:   t = 32'h000A_2F98;
      5'd11:   t = 32'h0005_17CC;
      5'd12:   t = 32'h0002_8BE6;
      5'd13:   t = 32'h0001_45F3;
      5'd14:   t = 32'h0000_A2F9;
      5'd15:   t = 32'h0000_517C;
      5'd16:   t = 32'h0000_28BE;
      5'd17:   t = 32'h0000_145F;
      5'd18:   t = 32'h0000_0A2F;
      5'd19:   t = 32'h0000_0517;
      5'd20:   t = 32'h0000_028B;
      5'd21:   t = 32'h0000_0145;
      5'd22:   t = 32'h0000_00A2;
      5'd23:   t = 32'h0000_0051;
      default: t = 32'h0000_0000;
    endcase
    r = {1'b0, t} + (33'd1 << (31 - phase_w));
    r = r >> (32 - phase_w);
    return r[31:0];
  endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation; the direction comes from the sign of z
// (rotation) or of y (vectoring), and the mode/valid tags ride along.
module cordic_stage
  import cordic_pkg::*;
#(
  parameter int                 W       = 21,
  parameter int                 PHASE_W = 20,
  parameter int                 SHIFT   = 0,
  parameter logic [PHASE_W-1:0] ATAN    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic                      mode_i,
  input  logic signed [W-1:0]       x_i,
  input  logic signed [W-1:0]       y_i,
  input  logic        [PHASE_W-1:0] z_i,
  output logic                      valid_o,
  output logic                      mode_o,
  output logic signed [W-1:0]       x_o,
  output logic signed [W-1:0]       y_o,
  output logic        [PHASE_W-1:0] z_o
);

  logic                 dir_pos_s;
  logic signed [W-1:0]  x_sh_s, y_sh_s;
  logic signed [W-1:0]  x_d, y_d, x_q, y_q;
  logic [PHASE_W-1:0]   z_d, z_q;
  logic                 valid_q, mode_q;

  always_comb begin
    dir_pos_s = 1'b0;
    x_sh_s    = x_i >>> SHIFT;
    y_sh_s    = y_i >>> SHIFT;
    if (mode_i == MODE_VEC) begin
      dir_pos_s = y_i[W-1];
    end else begin
      dir_pos_s = ~z_i[PHASE_W-1];
    end
    if (dir_pos_s) begin
      x_d = x_i - y_sh_s;
      y_d = y_i + x_sh_s;
      z_d = z_i - ATAN;
    end else begin
      x_d = x_i + y_sh_s;
      y_d = y_i - x_sh_s;
      z_d = z_i + ATAN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
    end else begin
      valid_q <= valid_i;
      mode_q  <= mode_i;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
    end
  end

  assign valid_o = valid_q;
  assign mode_o  = mode_q;
  assign x_o     = x_q;
  assign y_o     = y_q;
  assign z_o     = z_q;

endmodule

// File: rtl/cordic_rotvec.sv
// Fully pipelined rotation/vectoring CORDIC: quadrant pre-rotation register,
// STAGES micro-rotations, then a rounding output register (latency STAGES+2).
module cordic_rotvec
  import cordic_pkg::*;
#(
  parameter  int IN_W    = 16,
  parameter  int PHASE_W = 20,
  parameter  int STAGES  = 17,
  parameter  int GUARD   = 3,
  localparam int OUT_W   = IN_W + 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic                      mode,
  input  logic signed [IN_W-1:0]    i_in,
  input  logic signed [IN_W-1:0]    q_in,
  input  logic        [PHASE_W-1:0] phase_in,
  output logic                      out_valid,
  output logic                      mode_out,
  output logic signed [OUT_W-1:0]   iout,
  output logic signed [OUT_W-1:0]   qout,
  output logic        [PHASE_W-1:0] aout
);

  localparam int                  W     = IN_W + 2 + GUARD;
  localparam int                  RND_I = 32'sd1 << (GUARD - 1);
  localparam logic signed [W-1:0] RND   = RND_I[W-1:0];

  logic signed [W-1:0]  x_ext_s, y_ext_s;
  logic signed [W-1:0]  x0_d, y0_d, x0_q, y0_q;
  logic [PHASE_W-1:0]   z0_d, z0_q;
  logic                 v0_q, m0_q;

  logic signed [W-1:0]  x_s [STAGES+1];
  logic signed [W-1:0]  y_s [STAGES+1];
  logic [PHASE_W-1:0]   z_s [STAGES+1];
  logic                 v_s [STAGES+1];
  logic                 m_s [STAGES+1];

  logic signed [W-1:0]     x_rnd_s, y_rnd_s;
  logic                    is_zero_s;
  logic                    unused_s;
  logic signed [OUT_W-1:0] iout_d, qout_d, iout_q, qout_q;
  logic [PHASE_W-1:0]      aout_d, aout_q;
  logic                    valid_q, mode_q;

  // two-bit headroom makes negating the most negative input exact
  assign x_ext_s = {{2{i_in[IN_W-1]}}, i_in, {GUARD{1'b0}}};
  assign y_ext_s = {{2{q_in[IN_W-1]}}, q_in, {GUARD{1'b0}}};

  always_comb begin
    x0_d = x_ext_s;
    y0_d = y_ext_s;
    z0_d = phase_in;
    if (mode == MODE_VEC) begin
      if (i_in[IN_W-1]) begin
        x0_d = -x_ext_s;
        y0_d = -y_ext_s;
        z0_d = {1'b1, {(PHASE_W-1){1'b0}}};
      end else begin
        z0_d = '0;
      end
    end else begin
      if (phase_in[PHASE_W-1] ^ phase_in[PHASE_W-2]) begin
        x0_d = -x_ext_s;
        y0_d = -y_ext_s;
        z0_d = {~phase_in[PHASE_W-1], phase_in[PHASE_W-2:0]};
      end else begin
        z0_d = phase_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      m0_q <= 1'b0;
      x0_q <= '0;
      y0_q <= '0;
      z0_q <= '0;
    end else begin
      v0_q <= in_valid;
      m0_q <= mode;
      x0_q <= x0_d;
      y0_q <= y0_d;
      z0_q <= z0_d;
    end
  end

  assign x_s[0] = x0_q;
  assign y_s[0] = y0_q;
  assign z_s[0] = z0_q;
  assign v_s[0] = v0_q;
  assign m_s[0] = m0_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam logic [31:0] ATAN32 = atan_const(5'(k), PHASE_W);
    cordic_stage #(
      .W       (W),
      .PHASE_W (PHASE_W),
      .SHIFT   (k),
      .ATAN    (ATAN32[PHASE_W-1:0])
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (v_s[k]),
      .mode_i  (m_s[k]),
      .x_i     (x_s[k]),
      .y_i     (y_s[k]),
      .z_i     (z_s[k]),
      .valid_o (v_s[k+1]),
      .mode_o  (m_s[k+1]),
      .x_o     (x_s[k+1]),
      .y_o     (y_s[k+1]),
      .z_o     (z_s[k+1])
    );
  end

  // a zero vector never moves, so its accumulated angle is meaningless and forced to 0
  always_comb begin
    x_rnd_s   = x_s[STAGES] + RND;
    y_rnd_s   = y_s[STAGES] + RND;
    is_zero_s = (x_s[STAGES] == '0) && (y_s[STAGES] == '0);
    iout_d    = x_rnd_s[W-1:GUARD];
    qout_d    = y_rnd_s[W-1:GUARD];
    if ((m_s[STAGES] == MODE_VEC) && !is_zero_s) begin
      aout_d = z_s[STAGES];
    end else begin
      aout_d = '0;
    end
  end

  assign unused_s = ^{x_rnd_s[GUARD-1:0], y_rnd_s[GUARD-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
      iout_q  <= '0;
      qout_q  <= '0;
      aout_q  <= '0;
    end else begin
      valid_q <= v_s[STAGES];
      mode_q  <= m_s[STAGES];
      iout_q  <= iout_d;
      qout_q  <= qout_d;
      aout_q  <= aout_d;
    end
  end

  assign out_valid = valid_q;
  assign mode_out  = mode_q;
  assign iout      = iout_q;
  assign qout      = qout_q;
  assign aout      = aout_q;

endmodule

// File: tb/tb_cordic_rotvec.sv
// Directed vector table, async-reset sequence and a randomly gapped, mode-interleaved
// stream checked against a floating-point CORDIC reference (gain K of 17 iterations).
module tb_cordic_rotvec;

  localparam int  IN_W    = 16;
  localparam int  PHASE_W = 20;
  localparam int  STAGES  = 17;
  localparam int  GUARD   = 3;
  localparam int  OUT_W   = IN_W + 2;
  localparam int  LAT     = STAGES + 2;
  localparam real KGAIN   = 1.6467602581210654;
  localparam real PI      = 3.14159265358979323846;
  localparam real HALF_TURN = 524288.0;

  logic                      clk      = 1'b0;
  logic                      rst_n    = 1'b0;
  logic                      in_valid = 1'b0;
  logic                      mode     = 1'b0;
  logic signed [IN_W-1:0]    i_in     = '0;
  logic signed [IN_W-1:0]    q_in     = '0;
  logic        [PHASE_W-1:0] phase_in = '0;
  logic                      out_valid;
  logic                      mode_out;
  logic signed [OUT_W-1:0]   iout;
  logic signed [OUT_W-1:0]   qout;
  logic        [PHASE_W-1:0] aout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cordic_rotvec #(
    .IN_W    (IN_W),
    .PHASE_W (PHASE_W),
    .STAGES  (STAGES),
    .GUARD   (GUARD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .mode      (mode),
    .i_in      (i_in),
    .q_in      (q_in),
    .phase_in  (phase_in),
    .out_valid (out_valid),
    .mode_out  (mode_out),
    .iout      (iout),
    .qout      (qout),
    .aout      (aout)
  );

  typedef struct {
    logic md;
    int   i;
    int   q;
    int   ph;
    int   ei;
    int   eq;
    int   ea;
    int   tiq;
    int   ta;
  } vec_t;

  typedef struct {
    logic v;
    logic md;
    int   i;
    int   q;
    int   ph;
  } smp_t;

  task automatic chk(input string name, input longint act, input real exp, input real tol);
    real d;
    total++;
    d = real'(act) - exp;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got %0d want %0.2f (tol %0.1f)", name, act, exp, tol);
    end
  endtask

  task automatic chk_ang(input string name, input logic [PHASE_W-1:0] act, input real exp,
                         input real tol);
    real d;
    total++;
    d = real'(act) - exp;
    while (d > HALF_TURN)   d = d - 2.0 * HALF_TURN;
    while (d <= -HALF_TURN) d = d + 2.0 * HALF_TURN;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s: got 0x%05h want %0.2f (tol %0.1f)", name, act, exp, tol);
    end
  endtask

  task automatic model(input smp_t s, output real ei, output real eq, output real ea);
    real phi;
    if (s.md) begin
      ei = KGAIN * $sqrt(real'(s.i) * real'(s.i) + real'(s.q) * real'(s.q));
      eq = 0.0;
      ea = $atan2(real'(s.q), real'(s.i)) / PI * HALF_TURN;
      if (ea < 0.0) ea = ea + 2.0 * HALF_TURN;
    end else begin
      phi = real'(s.ph) * PI / HALF_TURN;
      ei  = KGAIN * (real'(s.i) * $cos(phi) - real'(s.q) * $sin(phi));
      eq  = KGAIN * (real'(s.i) * $sin(phi) + real'(s.q) * $cos(phi));
      ea  = 0.0;
    end
  endtask

  // one isolated sample: measure latency, then compare the emerging result
  task automatic apply_one(input vec_t v, input string tag);
    int lat;
    lat = -1;
    @(negedge clk);
    in_valid = 1'b1;
    mode     = v.md;
    i_in     = v.i[IN_W-1:0];
    q_in     = v.q[IN_W-1:0];
    phase_in = v.ph[PHASE_W-1:0];
    for (int c = 1; c <= LAT + 4 && lat < 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) lat = c;
    end
    chk({tag, " latency"}, lat, real'(LAT), 0.0);
    chk({tag, " mode_out"}, mode_out, real'(v.md), 0.0);
    chk({tag, " iout"}, iout, real'(v.ei), real'(v.tiq));
    chk({tag, " qout"}, qout, real'(v.eq), real'(v.tiq));
    chk_ang({tag, " aout"}, aout, real'(v.ea), real'(v.ta));
  endtask

  vec_t tbl[11];
  smp_t pipe[$];

  initial begin
    smp_t e, s;
    real  ei, eq, ea;
    int   seen;

    // expected magnitudes are K * |v| with K = 1.64676 (17 iterations)
    tbl[0]  = '{1'b0,  16384,      0, 32'h00000,  26981,      0, 32'h00000, 2, 0};
    tbl[1]  = '{1'b0,  16384,      0, 32'h40000,      0,  26981, 32'h00000, 2, 0};
    tbl[2]  = '{1'b0,  16384,      0, 32'h80000, -26981,      0, 32'h00000, 2, 0};
    tbl[3]  = '{1'b0,      0,  16384, 32'hC0000,  26981,      0, 32'h00000, 2, 0};
    tbl[4]  = '{1'b0, -32768, -32768, 32'h80000,  53961,  53961, 32'h00000, 3, 0};
    tbl[5]  = '{1'b0,  12000,  -5000, 32'h15555,  21231,   2750, 32'h00000, 3, 0};
    tbl[6]  = '{1'b1,  16384,  16384, 32'h12345,  38156,      0, 32'h20000, 3, 4};
    tbl[7]  = '{1'b1, -16384,      0, 32'h00000,  26981,      0, 32'h80000, 2, 4};
    tbl[8]  = '{1'b1, -32768, -32768, 32'h00000,  76312,      0, 32'hA0000, 3, 4};
    tbl[9]  = '{1'b1,      0,      0, 32'h40000,      0,      0, 32'h00000, 0, 0};
    tbl[10] = '{1'b1,      0, -16384, 32'h00000,  26981,      0, 32'hC0000, 2, 4};

    repeat (3) @(negedge clk);
    chk("reset out_valid", out_valid, 0.0, 0.0);
    chk("reset mode_out", mode_out, 0.0, 0.0);
    chk("reset iout", iout, 0.0, 0.0);
    chk("reset qout", qout, 0.0, 0.0);
    chk("reset aout", aout, 0.0, 0.0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int n = 0; n < 11; n++) begin
      apply_one(tbl[n], $sformatf("vec%0d", n));
    end

    // asynchronous reset in the middle of a running vectoring stream
    @(negedge clk);
    in_valid = 1'b1;
    mode     = 1'b1;
    i_in     = -16'sd16384;
    q_in     = 16'sd0;
    phase_in = '0;
    repeat (LAT + 3) @(negedge clk);
    chk("stream out_valid", out_valid, 1.0, 0.0);
    chk_ang("stream aout", aout, 524288.0, 4.0);
    #2 rst_n = 1'b0;
    #1;
    chk("async out_valid", out_valid, 0.0, 0.0);
    chk("async mode_out", mode_out, 0.0, 0.0);
    chk("async iout", iout, 0.0, 0.0);
    chk("async qout", qout, 0.0, 0.0);
    chk("async aout", aout, 0.0, 0.0);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (LAT + 6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("idle after reset", seen, 0.0, 0.0);
    apply_one(tbl[7], "post-reset");

    // interleaved modes every cycle, random gaps, compared against the reference
    for (int n = 0; n < LAT; n++) begin
      s = '{1'b0, 1'b0, 0, 0, 0};
      pipe.push_back(s);
    end
    for (int c = 0; c < 14000 + LAT; c++) begin
      @(negedge clk);
      e = pipe.pop_front();
      chk("il out_valid", out_valid, real'(e.v), 0.0);
      if (e.v) begin
        model(e, ei, eq, ea);
        chk("il mode_out", mode_out, real'(e.md), 0.0);
        chk("il iout", iout, ei, 3.0);
        chk("il qout", qout, eq, 3.0);
        if (e.md) chk_ang("il aout", aout, ea, 24.0);
        else      chk("il aout", aout, 0.0, 0.0);
      end
      s.v  = (c < 14000) && ($urandom_range(0, 3) != 0);
      s.md = c[0];
      s.i  = int'($urandom_range(0, 65534)) - 32767;
      s.q  = int'($urandom_range(0, 65534)) - 32767;
      s.ph = int'($urandom_range(0, 1048575));
      // vectoring angles are only resolvable to a few LSB on reasonably large vectors
      if (s.md && (s.i > -16000) && (s.i < 16000) && (s.q > -16000) && (s.q < 16000)) begin
        s.i = (s.i < 0) ? s.i - 16000 : s.i + 16000;
      end
      in_valid = s.v;
      mode     = s.md;
      i_in     = s.i[IN_W-1:0];
      q_in     = s.q[IN_W-1:0];
      phase_in = s.ph[PHASE_W-1:0];
      pipe.push_back(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
